pwm_bank: RTL

PWM_BANK -- requirements
Module: pwm_bank

---
 rtl/pwm_bank_pkg.sv | 34 +++
 rtl/pwm_bank_timebase.sv | 83 ++++++++
 rtl/pwm_bank.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pwm_bank_pkg.sv
// Register map, CTRL/STATUS bit positions and counter mode encoding shared by pwm_bank.
// Pure declarations; adds no latency and has no flow control.
package pwm_bank_pkg;

   localparam int ADDR_CTRL     = 0;
   localparam int ADDR_PERIOD   = 1;
   localparam int ADDR_PRESCALE = 2;
   localparam int ADDR_STATUS   = 3;
   localparam int ADDR_DUTY0    = 4;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_MODE_BIT   = 1;
   localparam int CTRL_INV_BIT    = 2;
   localparam int CTRL_IRQ_EN_BIT = 3;
   localparam int STATUS_WRAP_BIT = 0;

   typedef enum logic {
      MODE_EDGE   = 1'b0,
      MODE_CENTER = 1'b1
   } pwm_mode_e;

   // Member order puts en at bit 0 so the struct matches the CTRL word layout.
   typedef struct packed {
      logic      irq_en;
      logic      inv;
      pwm_mode_e mode;
      logic      en;
   } ctrl_t;

   function automatic logic [31:0] ctrl_word(input ctrl_t c);
      return {28'd0, c};
   endfunction

endpackage

// File: rtl/pwm_bank_timebase.sv
// Shared prescaler and up / up-down period counter; flags the tick that ends a PWM period.
// count moves one edge after each tick; boundary is combinational on the ending tick; no backpressure.
module pwm_bank_timebase
   import pwm_bank_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  pwm_mode_e             mode,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [WIDTH-1:0]      period,
   output logic [WIDTH-1:0]      count,
   output logic                  boundary
);

   localparam logic [WIDTH-1:0]      CNT_ONE   = WIDTH'(1);
   localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] presc_cnt;
   logic                  dir_down;
   logic                  tick;
   logic                  wrap;
   logic [WIDTH-1:0]      count_nxt;
   logic                  dir_nxt;

   assign tick     = en && (presc_cnt >= prescale);
   assign boundary = tick && wrap;

   always_comb begin
      count_nxt = count;
      dir_nxt   = dir_down;
      wrap      = 1'b0;
      if (period == '0) begin
         count_nxt = '0;
         dir_nxt   = 1'b0;
         wrap      = 1'b1;
      end else if (mode == MODE_EDGE) begin
         dir_nxt = 1'b0;
         if (count >= period) begin
            count_nxt = '0;
            wrap      = 1'b1;
         end else begin
            count_nxt = count + CNT_ONE;
         end
      end else if (!dir_down) begin
         // Turning around without moving holds each endpoint for a second tick.
         if (count >= period - CNT_ONE) begin
            dir_nxt = 1'b1;
         end else begin
            count_nxt = count + CNT_ONE;
         end
      end else begin
         if (count == '0) begin
            dir_nxt = 1'b0;
            wrap    = 1'b1;
         end else begin
            count_nxt = count - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_cnt <= '0;
         count     <= '0;
         dir_down  <= 1'b0;
      end else if (!en) begin
         presc_cnt <= '0;
         count     <= '0;
         dir_down  <= 1'b0;
      end else begin
         presc_cnt <= tick ? '0 : presc_cnt + PRESC_ONE;
         if (tick) begin
            count    <= count_nxt;
            dir_down <= dir_nxt;
         end
      end
   end

endmodule

// File: rtl/pwm_bank.sv
// Register-mapped bank of double-buffered PWM channels sharing one timebase.
// Writes act on the access edge; rdata and pwm_out are registered (1 cycle); always ready, no backpressure.
module pwm_bank
   import pwm_bank_pkg::*;
#(
   parameter int CHANNELS   = 8,
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 16,
   parameter int ADDR_W     = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cs,
   input  logic                we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_irq
);

   ctrl_t                             ctrl;
   pwm_mode_e                         mode_act;
   logic [WIDTH-1:0]                  period_sh;
   logic [WIDTH-1:0]                  period_act;
   logic [PRESCALE_W-1:0]             prescale;
   logic                              wrap;
   logic [CHANNELS-1:0][WIDTH-1:0]    duty_sh;
   logic [CHANNELS-1:0][WIDTH-1:0]    duty_act;
   logic [WIDTH-1:0]                  count;
   logic                              boundary;
   logic                              wr;
   logic                              rd;
   logic                              wr_ctrl;
   logic                              wr_period;
   logic                              wr_prescale;
   logic                              wr_status;
   logic                              en_rise;
   logic                              load_act;
   logic [CHANNELS-1:0]               raw;
   logic [31:0]                       rd_mux;
   logic                              unused_wdata;

   assign wr          = cs & we;
   assign rd          = cs & ~we;
   assign wr_ctrl     = wr && (addr == ADDR_W'(ADDR_CTRL));
   assign wr_period   = wr && (addr == ADDR_W'(ADDR_PERIOD));
   assign wr_prescale = wr && (addr == ADDR_W'(ADDR_PRESCALE));
   assign wr_status   = wr && (addr == ADDR_W'(ADDR_STATUS));
   assign unused_wdata = ^wdata;

   // Enabling reloads the active set on the very edge that writes EN, so the first period is clean.
   assign en_rise  = wr_ctrl & wdata[CTRL_EN_BIT] & ~ctrl.en;
   assign load_act = boundary | en_rise;

   assign period_irq = wrap & ctrl.irq_en;

   pwm_bank_timebase #(
      .WIDTH      (WIDTH),
      .PRESCALE_W (PRESCALE_W)
   ) u_timebase (
      .clk      (clk),
      .rst      (rst),
      .en       (ctrl.en),
      .mode     (mode_act),
      .prescale (prescale),
      .period   (period_act),
      .count    (count),
      .boundary (boundary)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl       <= '0;
         mode_act   <= MODE_EDGE;
         period_sh  <= '1;
         period_act <= '1;
         prescale   <= '0;
         wrap       <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            ctrl.en     <= wdata[CTRL_EN_BIT];
            ctrl.mode   <= pwm_mode_e'(wdata[CTRL_MODE_BIT]);
            ctrl.inv    <= wdata[CTRL_INV_BIT];
            ctrl.irq_en <= wdata[CTRL_IRQ_EN_BIT];
         end
         if (wr_period) begin
            period_sh <= wdata[WIDTH-1:0];
         end
         if (wr_prescale) begin
            prescale <= wdata[PRESCALE_W-1:0];
         end
         if (en_rise) begin
            mode_act <= pwm_mode_e'(wdata[CTRL_MODE_BIT]);
         end else if (boundary) begin
            mode_act <= ctrl.mode;
         end
         if (load_act) begin
            period_act <= period_sh;
         end
         // A boundary wins over a same-cycle software clear.
         wrap <= boundary | (wrap & ~(wr_status & wdata[STATUS_WRAP_BIT]));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_sh  <= '0;
         duty_act <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (load_act) begin
               duty_act[i] <= duty_sh[i];
            end
            if (wr && (addr == ADDR_W'(ADDR_DUTY0 + i))) begin
               duty_sh[i] <= wdata[WIDTH-1:0];
            end
         end
      end
   end

   always_comb begin
      raw = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         raw[i] = (count < duty_act[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_out <= '0;
      end else if (ctrl.en) begin
         pwm_out <= raw ^ {CHANNELS{ctrl.inv}};
      end else begin
         pwm_out <= {CHANNELS{ctrl.inv}};
      end
   end

   always_comb begin
      rd_mux = '0;
      if (addr == ADDR_W'(ADDR_CTRL)) begin
         rd_mux = ctrl_word(ctrl);
      end else if (addr == ADDR_W'(ADDR_PERIOD)) begin
         rd_mux = 32'(period_sh);
      end else if (addr == ADDR_W'(ADDR_PRESCALE)) begin
         rd_mux = 32'(prescale);
      end else if (addr == ADDR_W'(ADDR_STATUS)) begin
         rd_mux = 32'(wrap);
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (addr == ADDR_W'(ADDR_DUTY0 + i)) begin
               rd_mux = 32'(duty_sh[i]);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else begin
         rdata <= rd ? rd_mux : '0;
      end
   end

endmodule
